// File: rtl/hex_digest_rx_if.sv
// Byte stream from uart_rx into the hex-digest receiver.
// byteReady is a one-cycle strobe qualifying dataIn.
interface hex_digest_rx_if;
  logic       byteReady;
  logic [7:0] dataIn;

  modport master (output byteReady, output dataIn);
  modport slave  (input  byteReady, input  dataIn);
endinterface

// File: rtl/hex_digest_rx.sv
// Receive side of the hex-digest link: decodes ASCII hex into a NIBBLES*4-bit digest
// (first character in the MSBs) and reports match/mismatch against the local hash.
module hex_digest_rx #(
  parameter int unsigned NIBBLES     = 64,
  parameter int unsigned TIMEOUT_CYC = 27000000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  hex_digest_rx_if.slave                 rx,
  input  logic                           clear,
  input  logic [NIBBLES*4-1:0]           expected,
  input  logic                           expected_valid,
  output logic [NIBBLES*4-1:0]           digest,
  output logic [$clog2(NIBBLES+1)-1:0]   nib_count,
  output logic                           digest_valid,
  output logic                           match,
  output logic                           mismatch,
  output logic                           err
);

  localparam int unsigned DW    = NIBBLES * 4;
  localparam int unsigned CW    = $clog2(NIBBLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYC);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(NIBBLES - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(NIBBLES);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    digest_d;
  logic [CW-1:0]    cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             dv_d, match_d, mism_d, err_d;

  logic             is_hex, is_sep;
  logic [3:0]       nib;

  // ASCII decode of the received byte
  always_comb begin
    is_hex = 1'b0;
    is_sep = 1'b0;
    nib    = 4'h0;
    if (rx.dataIn >= 8'h30 && rx.dataIn <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(rx.dataIn - 8'h30);
    end else if (rx.dataIn >= 8'h61 && rx.dataIn <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(rx.dataIn - 8'h57);
    end else if (rx.dataIn >= 8'h41 && rx.dataIn <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(rx.dataIn - 8'h37);
    end else if (rx.dataIn == 8'h0D || rx.dataIn == 8'h0A || rx.dataIn == 8'h20) begin
      is_sep = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    digest_d = digest;
    cnt_d    = nib_count;
    tmo_d    = tmo_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    match_d  = match;
    mism_d   = mismatch;

    if (clear) begin
      state_d  = IDLE;
      digest_d = '0;
      cnt_d    = '0;
      tmo_d    = '0;
      match_d  = 1'b0;
      mism_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          tmo_d = '0;
          if (state_q == DONE) begin
            state_d = IDLE;
            dv_d    = 1'b1;
            if (expected_valid) begin
              match_d = (digest == expected);
              mism_d  = (digest != expected);
            end
          end
          // A byte arriving in DONE is treated as the first byte of the next digest
          if (rx.byteReady) begin
            if (is_hex) begin
              state_d  = (CNT_ONE == CNT_FULL) ? DONE : COLLECT;
              digest_d = DW'(nib);
              cnt_d    = CNT_ONE;
              if (state_q == IDLE) begin
                match_d = 1'b0;
                mism_d  = 1'b0;
              end
            end else if (!is_sep) begin
              err_d = 1'b1;
            end
          end
        end
        COLLECT: begin
          if (tmo_q >= TMO_LIM) begin
            state_d  = IDLE;
            digest_d = '0;
            cnt_d    = '0;
            tmo_d    = '0;
            err_d    = 1'b1;
          end else if (rx.byteReady && is_hex) begin
            digest_d = {digest[DW-5:0], nib};
            cnt_d    = nib_count + CNT_ONE;
            tmo_d    = '0;
            if (nib_count == CNT_LAST) state_d = DONE;
          end else if (rx.byteReady && !is_sep) begin
            state_d  = IDLE;
            digest_d = '0;
            cnt_d    = '0;
            tmo_d    = '0;
            err_d    = 1'b1;
          end else if (tmo_q != TMO_LIM) begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      digest       <= '0;
      nib_count    <= '0;
      tmo_q        <= '0;
      digest_valid <= 1'b0;
      match        <= 1'b0;
      mismatch     <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      digest       <= digest_d;
      nib_count    <= cnt_d;
      tmo_q        <= tmo_d;
      digest_valid <= dv_d;
      match        <= match_d;
      mismatch     <= mism_d;
      err          <= err_d;
    end
  end

endmodule
